// File: rtl/rnic_lite_cfg_seq.sv
// Configuration sequencer: walks a (address, data) table into the AXI-lite
// transaction generator, then waits for traffic completion and read-back.
module rnic_lite_cfg_seq #(
    parameter int C_S_AXI_LITE_ADDR_WIDTH = 32,
    parameter int C_S_AXI_LITE_DATA_WIDTH = 32,
    parameter int C_TBL_DEPTH             = 16,
    parameter int C_IDX_W                 = 4,
    parameter int C_TIMEOUT               = 1024,
    parameter int C_TO_W                  = 16
) (
    input  logic                               s_axi_lite_aclk,
    input  logic                               s_axi_lite_arstn,
    input  logic                               tbl_wr_en,
    input  logic [C_IDX_W-1:0]                 tbl_wr_idx,
    input  logic [C_S_AXI_LITE_ADDR_WIDTH-1:0] tbl_wr_addr,
    input  logic [C_S_AXI_LITE_DATA_WIDTH-1:0] tbl_wr_data,
    input  logic [C_IDX_W:0]                   i_num_entries,
    input  logic                               i_start,
    output logic                               o_gen_txns,
    output logic [C_S_AXI_LITE_ADDR_WIDTH-1:0] o_addr,
    output logic [C_S_AXI_LITE_DATA_WIDTH-1:0] o_data,
    input  logic                               i_txns_done,
    input  logic                               i_traffic_done,
    output logic                               o_test_completed,
    input  logic                               i_final_reg_read_done,
    output logic                               o_busy,
    output logic                               o_cfg_done,
    output logic                               o_done,
    output logic                               o_error,
    output logic [1:0]                         o_err_state,
    output logic [C_IDX_W-1:0]                 o_cur_idx,
    output logic [C_IDX_W:0]                   o_wr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_WR,
        S_TRAFFIC,
        S_RDBACK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [C_IDX_W:0]  LP_DEPTH   = (C_IDX_W+1)'(C_TBL_DEPTH);
    localparam logic [C_TO_W-1:0] LP_TO_LAST = C_TO_W'(C_TIMEOUT - 1);

    state_t                             r_state;
    logic [C_S_AXI_LITE_ADDR_WIDTH-1:0] r_tbl_addr [C_TBL_DEPTH];
    logic [C_S_AXI_LITE_DATA_WIDTH-1:0] r_tbl_data [C_TBL_DEPTH];
    logic [C_IDX_W:0]                   r_n;
    logic [C_TO_W-1:0]                  r_timer;

    logic                               r_gen_txns;
    logic [C_S_AXI_LITE_ADDR_WIDTH-1:0] r_addr;
    logic [C_S_AXI_LITE_DATA_WIDTH-1:0] r_data;
    logic                               r_test_completed;
    logic                               r_busy;
    logic                               r_cfg_done;
    logic                               r_done;
    logic                               r_error;
    logic [1:0]                         r_err_state;
    logic [C_IDX_W-1:0]                 r_cur_idx;
    logic [C_IDX_W:0]                   r_wr_cnt;

    logic [C_IDX_W:0]                   w_n_eff;
    logic [C_IDX_W-1:0]                 w_next_idx;
    logic                               w_last;
    logic                               w_timeout;

    assign w_n_eff    = (i_num_entries > LP_DEPTH) ? LP_DEPTH : i_num_entries;
    assign w_next_idx = r_cur_idx + C_IDX_W'(1);
    assign w_last     = ({1'b0, r_cur_idx} == (r_n - (C_IDX_W+1)'(1)));
    assign w_timeout  = (r_timer == LP_TO_LAST);

    // Table is plain storage: survives reset so a restart can reuse it.
    always_ff @(posedge s_axi_lite_aclk) begin
        if (r_state == S_IDLE && tbl_wr_en) begin
            r_tbl_addr[tbl_wr_idx] <= tbl_wr_addr;
            r_tbl_data[tbl_wr_idx] <= tbl_wr_data;
        end
    end

    always_ff @(posedge s_axi_lite_aclk) begin
        if (!s_axi_lite_arstn) begin
            r_state          <= S_IDLE;
            r_n              <= '0;
            r_timer          <= '0;
            r_gen_txns       <= 1'b0;
            r_addr           <= '0;
            r_data           <= '0;
            r_test_completed <= 1'b0;
            r_busy           <= 1'b0;
            r_cfg_done       <= 1'b0;
            r_done           <= 1'b0;
            r_error          <= 1'b0;
            r_err_state      <= 2'b00;
            r_cur_idx        <= '0;
            r_wr_cnt         <= '0;
        end else begin
            r_gen_txns <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_busy <= 1'b1;
                        if (w_n_eff != '0) begin
                            r_n        <= w_n_eff;
                            r_addr     <= r_tbl_addr[0];
                            r_data     <= r_tbl_data[0];
                            r_gen_txns <= 1'b1;
                            r_cur_idx  <= '0;
                            r_timer    <= '0;
                            r_state    <= S_WAIT_WR;
                        end else begin
                            r_cfg_done <= 1'b1;
                            r_state    <= S_TRAFFIC;
                        end
                    end
                end
                // Address/data stay put until acked: the generator retries from them.
                S_WAIT_WR: begin
                    if (i_txns_done) begin
                        r_wr_cnt <= r_wr_cnt + (C_IDX_W+1)'(1);
                        if (w_last) begin
                            r_cfg_done <= 1'b1;
                            r_state    <= S_TRAFFIC;
                        end else begin
                            r_cur_idx  <= w_next_idx;
                            r_addr     <= r_tbl_addr[w_next_idx];
                            r_data     <= r_tbl_data[w_next_idx];
                            r_gen_txns <= 1'b1;
                            r_timer    <= '0;
                        end
                    end else if (w_timeout) begin
                        r_error     <= 1'b1;
                        r_err_state <= 2'b01;
                        r_busy      <= 1'b0;
                        r_state     <= S_ERR;
                    end else begin
                        r_timer <= r_timer + C_TO_W'(1);
                    end
                end
                S_TRAFFIC: begin
                    if (i_traffic_done) begin
                        r_test_completed <= 1'b1;
                        r_timer          <= '0;
                        r_state          <= S_RDBACK;
                    end
                end
                S_RDBACK: begin
                    if (i_final_reg_read_done) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_error     <= 1'b1;
                        r_err_state <= 2'b10;
                        r_busy      <= 1'b0;
                        r_state     <= S_ERR;
                    end else begin
                        r_timer <= r_timer + C_TO_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_gen_txns       = r_gen_txns;
    assign o_addr           = r_addr;
    assign o_data           = r_data;
    assign o_test_completed = r_test_completed;
    assign o_busy           = r_busy;
    assign o_cfg_done       = r_cfg_done;
    assign o_done           = r_done;
    assign o_error          = r_error;
    assign o_err_state      = r_err_state;
    assign o_cur_idx        = r_cur_idx;
    assign o_wr_cnt         = r_wr_cnt;

endmodule

// File: tb/tb_rnic_lite_cfg_seq.sv
// Directed bench for rnic_lite_cfg_seq: table walk, timeouts, N=0, hold,
// coincident done/timeout, mid-sequence reset and entry-count clamp.
module tb_rnic_lite_cfg_seq;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int DEP = 16;
    localparam int IW  = 4;
    localparam int TO  = 64;

    logic          clk;
    logic          rstn;
    logic          tbl_wr_en;
    logic [IW-1:0] tbl_wr_idx;
    logic [AW-1:0] tbl_wr_addr;
    logic [DW-1:0] tbl_wr_data;
    logic [IW:0]   num_entries;
    logic          start;
    logic          gen_txns;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          txns_done;
    logic          traffic_done;
    logic          test_completed;
    logic          rdback_done;
    logic          busy;
    logic          cfg_done;
    logic          done;
    logic          error;
    logic [1:0]    err_state;
    logic [IW-1:0] cur_idx;
    logic [IW:0]   wr_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    logic [AW-1:0] exp_addr [DEP];
    logic [DW-1:0] exp_data [DEP];

    rnic_lite_cfg_seq #(
        .C_S_AXI_LITE_ADDR_WIDTH(AW),
        .C_S_AXI_LITE_DATA_WIDTH(DW),
        .C_TBL_DEPTH(DEP),
        .C_IDX_W(IW),
        .C_TIMEOUT(TO),
        .C_TO_W(16)
    ) dut (
        .s_axi_lite_aclk(clk),
        .s_axi_lite_arstn(rstn),
        .tbl_wr_en(tbl_wr_en),
        .tbl_wr_idx(tbl_wr_idx),
        .tbl_wr_addr(tbl_wr_addr),
        .tbl_wr_data(tbl_wr_data),
        .i_num_entries(num_entries),
        .i_start(start),
        .o_gen_txns(gen_txns),
        .o_addr(addr),
        .o_data(data),
        .i_txns_done(txns_done),
        .i_traffic_done(traffic_done),
        .o_test_completed(test_completed),
        .i_final_reg_read_done(rdback_done),
        .o_busy(busy),
        .o_cfg_done(cfg_done),
        .o_done(done),
        .o_error(error),
        .o_err_state(err_state),
        .o_cur_idx(cur_idx),
        .o_wr_cnt(wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        logic [63:0] acc;
        acc = {63'(0), gen_txns} | 64'(addr) | 64'(data) | 64'(test_completed) | 64'(busy)
            | 64'(cfg_done) | 64'(done) | 64'(error) | 64'(err_state) | 64'(cur_idx) | 64'(wr_cnt);
        chk(tag, acc, 64'd0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic load(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
        tbl_wr_en   = 1'b1;
        tbl_wr_idx  = IW'(idx);
        tbl_wr_addr = a;
        tbl_wr_data = d;
        exp_addr[idx] = a;
        exp_data[idx] = d;
        tick();
        tbl_wr_en = 1'b0;
    endtask

    task automatic pulse_start(input int n);
        num_entries = (IW+1)'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_gen(input string tag);
        int n;
        n = 0;
        while (gen_txns !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk(tag, 64'(gen_txns), 64'd1);
    endtask

    // Generator model: sees the request, holds off 'delay' cycles, acks once.
    task automatic issue_write(input int idx, input int delay, input bit poke);
        bit stable;
        wait_gen("gen_seen");
        chk("addr", 64'(addr), 64'(exp_addr[idx]));
        chk("data", 64'(data), 64'(exp_data[idx]));
        chk("cur_idx", 64'(cur_idx), 64'(idx));
        tick();
        chk("gen_single", 64'(gen_txns), 64'd0);
        stable = 1'b1;
        for (int k = 1; k < delay; k++) begin
            if (poke && k == 1) begin
                tbl_wr_en   = 1'b1;
                tbl_wr_idx  = '0;
                tbl_wr_addr = 32'hDEAD_BEEF;
                tbl_wr_data = 32'h1234_5678;
            end
            tick();
            tbl_wr_en = 1'b0;
            if (addr !== exp_addr[idx] || data !== exp_data[idx] || gen_txns !== 1'b0)
                stable = 1'b0;
        end
        chk("hold_stable", 64'(stable), 64'd1);
        txns_done = 1'b1;
        tick();
        txns_done = 1'b0;
    endtask

    task automatic cycles_to_error(input string tag, input int expected);
        int n;
        n = 0;
        while (error !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 64'(n), 64'(expected));
    endtask

    initial begin
        rstn         = 1'b0;
        tbl_wr_en    = 1'b0;
        tbl_wr_idx   = '0;
        tbl_wr_addr  = '0;
        tbl_wr_data  = '0;
        num_entries  = '0;
        start        = 1'b0;
        txns_done    = 1'b0;
        traffic_done = 1'b0;
        rdback_done  = 1'b0;
        for (int i = 0; i < DEP; i++) begin
            exp_addr[i] = '0;
            exp_data[i] = '0;
        end

        // Reset state
        do_reset();
        chk_all_zero("reset_outputs");

        // Three-entry happy path
        load(0, 32'h5006_0020, 32'h0000_0001);
        load(1, 32'h5006_0024, 32'h0000_ABCD);
        load(2, 32'h5006_0028, 32'hFFFF_0000);
        pulse_start(3);
        chk("busy_after_start", 64'(busy), 64'd1);
        issue_write(0, 5, 1'b0);
        issue_write(1, 5, 1'b0);
        issue_write(2, 5, 1'b0);
        chk("cfg_done_3", 64'(cfg_done), 64'd1);
        chk("wr_cnt_3", 64'(wr_cnt), 64'd3);
        chk("cur_idx_last", 64'(cur_idx), 64'd2);
        chk("no_gen_after_last", 64'(gen_txns), 64'd0);
        chk("tc_before_traffic", 64'(test_completed), 64'd0);
        txns_done = 1'b1;
        tick();
        txns_done = 1'b0;
        chk("stray_done_ignored", 64'(wr_cnt), 64'd3);
        traffic_done = 1'b1;
        tick();
        traffic_done = 1'b0;
        chk("test_completed", 64'(test_completed), 64'd1);
        chk("busy_rdback", 64'(busy), 64'd1);
        tick();
        tick();
        rdback_done = 1'b1;
        tick();
        rdback_done = 1'b0;
        chk("done", 64'(done), 64'd1);
        chk("busy_done", 64'(busy), 64'd0);
        chk("no_error", 64'(error), 64'd0);
        pulse_start(3);
        chk("start_ignored_in_done", 64'(gen_txns), 64'd0);
        chk("tc_held", 64'(test_completed), 64'd1);

        // Write timeout on entry 1
        do_reset();
        pulse_start(3);
        issue_write(0, 5, 1'b0);
        wait_gen("gen_seen_e1");
        chk("cur_idx_e1", 64'(cur_idx), 64'd1);
        cycles_to_error("wr_timeout_cycles", TO);
        chk("err_state_wr", 64'(err_state), 64'd1);
        chk("cur_idx_frozen", 64'(cur_idx), 64'd1);
        chk("wr_cnt_to", 64'(wr_cnt), 64'd1);
        chk("tc_after_to", 64'(test_completed), 64'd0);
        chk("busy_err", 64'(busy), 64'd0);
        chk("cfg_done_to", 64'(cfg_done), 64'd0);

        // N=0 goes straight to traffic, then read-back timeout
        do_reset();
        pulse_start(0);
        chk("n0_no_gen", 64'(gen_txns), 64'd0);
        chk("n0_cfg_done", 64'(cfg_done), 64'd1);
        chk("n0_busy", 64'(busy), 64'd1);
        traffic_done = 1'b1;
        tick();
        traffic_done = 1'b0;
        chk("n0_test_completed", 64'(test_completed), 64'd1);
        cycles_to_error("rd_timeout_cycles", TO);
        chk("err_state_rd", 64'(err_state), 64'd2);
        chk("rd_to_not_done", 64'(done), 64'd0);

        // Long ack hold, table poke while busy, done coincident with timeout
        do_reset();
        pulse_start(2);
        issue_write(0, 40, 1'b1);
        issue_write(1, TO - 1, 1'b0);
        chk("coincident_no_error", 64'(error), 64'd0);
        chk("coincident_cfg_done", 64'(cfg_done), 64'd1);
        chk("coincident_wr_cnt", 64'(wr_cnt), 64'd2);
        do_reset();
        pulse_start(1);
        issue_write(0, 5, 1'b0);
        chk("rerun_cfg_done", 64'(cfg_done), 64'd1);

        // Mid-sequence reset, then clamped 20 -> 16 entries
        do_reset();
        for (int i = 3; i < DEP; i++)
            load(i, 32'h5006_0000 + 32'(4 * i), 32'hA5A5_0000 | 32'(i));
        pulse_start(20);
        issue_write(0, 2, 1'b0);
        issue_write(1, 2, 1'b0);
        wait_gen("gen_seen_e2");
        chk("cur_idx_e2", 64'(cur_idx), 64'd2);
        rstn = 1'b0;
        tick();
        chk_all_zero("midreset_outputs");
        rstn = 1'b1;
        tick();
        chk("no_gen_after_reset", 64'(gen_txns), 64'd0);
        pulse_start(20);
        for (int i = 0; i < DEP; i++)
            issue_write(i, 1, 1'b0);
        chk("clamp_wr_cnt", 64'(wr_cnt), 64'd16);
        chk("clamp_cfg_done", 64'(cfg_done), 64'd1);
        chk("clamp_cur_idx", 64'(cur_idx), 64'd15);
        tick();
        tick();
        chk("clamp_no_17th", 64'(gen_txns), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
